// File: rtl/cp_ifetch.sv
// rtl/cp_ifetch.sv - control-processor instruction fetch stage with one-entry stall hold register
// Optional macro CP_IF_FAST_REDIRECT_EN: branch target bypasses straight onto the imem address.
module cp_ifetch #(
  parameter int PC_WIDTH   = 13,
  parameter int INST_WIDTH = 28
) (
  input  logic                  iClk,
  input  logic                  iReset,
  input  logic                  iEnable,
  input  logic [PC_WIDTH-1:0]   iStart_PC,
  input  logic                  iStall,
  input  logic                  iBranch_Valid,
  input  logic [PC_WIDTH-1:0]   iBranch_Target,
  output logic [PC_WIDTH-1:0]   oIF_IMEM_Addr,
  input  logic [INST_WIDTH-1:0] iIMEM_IF_Instruction,
  output logic                  oIF_ID_Valid,
  output logic [INST_WIDTH-1:0] oIF_ID_Instruction,
  output logic [PC_WIDTH-1:0]   oIF_ID_PC
);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_e;

  state_e                  state_q, state_d;
  logic [PC_WIDTH-1:0]     fetch_pc_q, fetch_pc_d;
  logic [PC_WIDTH-1:0]     resp_pc_q, resp_pc_d;
  logic                    resp_valid_q, resp_valid_d;
  logic                    holding_q, holding_d;
  logic [INST_WIDTH-1:0]   hold_q, hold_d;

  always_ff @(posedge iClk or posedge iReset) begin
    if (iReset) begin
      state_q      <= IDLE;
      fetch_pc_q   <= '0;
      resp_pc_q    <= '0;
      resp_valid_q <= 1'b0;
      holding_q    <= 1'b0;
      hold_q       <= '0;
    end else begin
      state_q      <= state_d;
      fetch_pc_q   <= fetch_pc_d;
      resp_pc_q    <= resp_pc_d;
      resp_valid_q <= resp_valid_d;
      holding_q    <= holding_d;
      hold_q       <= hold_d;
    end
  end

  // Priority in RUN: halt, then branch, then stall, then advance.
  always_comb begin
    state_d      = state_q;
    fetch_pc_d   = fetch_pc_q;
    resp_pc_d    = resp_pc_q;
    resp_valid_d = resp_valid_q;
    holding_d    = holding_q;
    hold_d       = hold_q;
    if (state_q == IDLE) begin
      if (iEnable) begin
        state_d    = RUN;
        fetch_pc_d = iStart_PC;
      end
    end else if (!iEnable) begin
      state_d      = IDLE;
      resp_valid_d = 1'b0;
      holding_d    = 1'b0;
    end else if (iBranch_Valid) begin
      holding_d = 1'b0;
`ifdef CP_IF_FAST_REDIRECT_EN
      fetch_pc_d   = iBranch_Target + PC_WIDTH'(1);
      resp_pc_d    = iBranch_Target;
      resp_valid_d = 1'b1;
`else
      fetch_pc_d   = iBranch_Target;
      resp_valid_d = 1'b0;
`endif
    end else if (iStall) begin
      // imem output moves on to the next address after this cycle, so capture it now.
      if (resp_valid_q && !holding_q) begin
        hold_d    = iIMEM_IF_Instruction;
        holding_d = 1'b1;
      end
    end else begin
      fetch_pc_d   = fetch_pc_q + PC_WIDTH'(1);
      resp_pc_d    = fetch_pc_q;
      resp_valid_d = 1'b1;
      holding_d    = 1'b0;
    end
  end

`ifdef CP_IF_FAST_REDIRECT_EN
  assign oIF_IMEM_Addr = iBranch_Valid ? iBranch_Target : fetch_pc_q;
`else
  assign oIF_IMEM_Addr = fetch_pc_q;
`endif

  assign oIF_ID_Instruction = holding_q ? hold_q : iIMEM_IF_Instruction;
  assign oIF_ID_PC          = resp_pc_q;
  assign oIF_ID_Valid       = (state_q == RUN) && (holding_q || resp_valid_q);

endmodule

// File: tb/tb_cp_ifetch.sv
// tb/tb_cp_ifetch.sv - directed bench for cp_ifetch with stream-level reference model
module tb_cp_ifetch;

`ifdef CP_IF_FAST_REDIRECT_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        en, stall, br;
  logic [12:0] start_pc, tgt;
  logic [12:0] addr;
  logic [27:0] imem_q;
  logic        valid;
  logic [27:0] instr;
  logic [12:0] pc;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  cp_ifetch #(.PC_WIDTH(13), .INST_WIDTH(28)) dut (
    .iClk                 (clk),
    .iReset               (rst),
    .iEnable              (en),
    .iStart_PC            (start_pc),
    .iStall               (stall),
    .iBranch_Valid        (br),
    .iBranch_Target       (tgt),
    .oIF_IMEM_Addr        (addr),
    .iIMEM_IF_Instruction (imem_q),
    .oIF_ID_Valid         (valid),
    .oIF_ID_Instruction   (instr),
    .oIF_ID_PC            (pc)
  );

  function automatic logic [27:0] mem_word(input logic [12:0] a);
    return {a ^ 13'h1A5B, 2'b10, a + 13'h0777};
  endfunction

  always @(posedge clk) imem_q <= mem_word(addr);

  // Stream model: which PC is on the ID port, and which PC is pending after a start/redirect.
  logic        m_run, m_valid, m_pend;
  logic [12:0] m_pc, m_next, m_addr;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_run = 0; m_valid = 0; m_pend = 0; m_pc = 0; m_next = 0; m_addr = 0;
    end else begin
      if (!m_run) begin
        if (en) begin m_run = 1; m_pend = 1; m_next = start_pc; m_valid = 0; end
      end else if (!en) begin
        m_run = 0; m_valid = 0; m_pend = 0;
      end else if (br) begin
        if (FAST) begin m_valid = 1; m_pend = 0; m_pc = tgt; end
        else begin m_valid = 0; m_pend = 1; m_next = tgt; end
      end else if (!stall) begin
        if (m_valid) m_pc = m_pc + 13'd1;
        else if (m_pend) begin m_valid = 1; m_pc = m_next; m_pend = 0; end
      end
      if (m_run) m_addr = m_valid ? m_pc + 13'd1 : m_next;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      chk("model_valid", 32'(valid), 32'(m_valid));
      chk("model_addr", 32'(addr), 32'((FAST && br) ? tgt : m_addr));
      if (m_valid) begin
        chk("model_pc", 32'(pc), 32'(m_pc));
        chk("model_instr", 32'(instr), 32'(mem_word(m_pc)));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    rst = 1; en = 0; stall = 0; br = 0; start_pc = 0; tgt = 0;
    tick(); tick();
    chk("reset_valid", 32'(valid), 32'h0);
    chk("reset_pc", 32'(pc), 32'h0);
    chk("reset_addr", 32'(addr), 32'h0);
    rst = 0;
    tick();

    // start at 0x010
    en = 1; start_pc = 13'h010;
    tick();
    chk("start_gap_valid", 32'(valid), 32'h0);
    chk("start_addr", 32'(addr), 32'h010);
    tick();
    chk("first_valid", 32'(valid), 32'h1);
    chk("first_pc", 32'(pc), 32'h010);
    chk("first_instr", 32'(instr), 32'hD25C787);
    tick(); tick(); tick();
    chk("pc_013", 32'(pc), 32'h013);

    // three stall cycles while 0x013 is presented
    stall = 1;
    tick();
    chk("stall_pc", 32'(pc), 32'h013);
    tick(); tick();
    chk("stall_last_pc", 32'(pc), 32'h013);
    chk("stall_last_instr", 32'(instr), 32'(mem_word(13'h013)));
    stall = 0;
    tick();
    chk("after_stall_pc", 32'(pc), 32'h014);
    tick();
    chk("pc_015", 32'(pc), 32'h015);

    // redirect to 0x100
    br = 1; tgt = 13'h100;
    tick();
    br = 0;
    chk("redirect_gap", 32'(valid), 32'(FAST));
    if (!FAST) tick();
    chk("target_valid", 32'(valid), 32'h1);
    chk("target_pc", 32'(pc), 32'h100);
    tick();
    chk("target_next_pc", 32'(pc), 32'h101);

    // branch while holding a stalled word
    br = 1; tgt = 13'h020;
    tick();
    br = 0;
    if (!FAST) tick();
    chk("pc_020", 32'(pc), 32'h020);
    stall = 1;
    tick();
    chk("held_instr", 32'(instr), 32'(mem_word(13'h020)));
    br = 1; tgt = 13'h200;
    tick();
    br = 0; stall = 0;
    chk("hold_dropped", 32'(valid), 32'(FAST));
    if (!FAST) tick();
    chk("pc_200", 32'(pc), 32'h200);

    // halt, wraparound run
    en = 0;
    tick();
    chk("halt_valid", 32'(valid), 32'h0);
    en = 1; start_pc = 13'h1FFE;
    tick(); tick();
    chk("pc_1ffe", 32'(pc), 32'h1FFE);
    tick();
    chk("pc_1fff", 32'(pc), 32'h1FFF);
    chk("wrap_addr", 32'(addr), 32'h0000);
    tick();
    chk("pc_wrap", 32'(pc), 32'h0000);
    tick();
    chk("pc_0001", 32'(pc), 32'h0001);
    en = 0;
    tick();
    chk("halt2_valid", 32'(valid), 32'h0);
    en = 1; start_pc = 13'h040;
    tick(); tick();
    chk("restart_valid", 32'(valid), 32'h1);
    chk("restart_pc", 32'(pc), 32'h040);

    // redirect to 0x300, then async reset mid-stream
    br = 1; tgt = 13'h300;
    #1;
    chk("redirect_addr", 32'(addr), FAST ? 32'h300 : 32'h041);
    tick();
    br = 0;
    if (!FAST) tick();
    chk("pc_300", 32'(pc), 32'h300);
    tick();
    chk("pc_301", 32'(pc), 32'h301);
    #1;
    rst = 1;
    #1;
    chk("async_valid", 32'(valid), 32'h0);
    chk("async_pc", 32'(pc), 32'h0);
    chk("async_addr", 32'(addr), 32'h0);
    tick(); tick();
    rst = 0;
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
